// File: rtl/delay_pipe.sv
// delay_pipe: multi-channel, valid-tagged delay line with runtime-programmable latency.
//
// Ports:
//   clkIn      - clock, rising edge
//   rstIn      - asynchronous reset, active-low
//   enIn       - 1 = pipeline advances this edge, 0 = all stages hold
//   flushIn    - clears all in-flight valid bits (data bits untouched)
//   latencyIn  - requested latency, 1..MAX_LATENCY (out-of-range values are clamped)
//   validIn    - sample on dataIn is valid
//   dataIn     - NUM_CH channels, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   validOut   - valid bit of stage curLat-1
//   dataOut    - data of stage curLat-1
//   busyOut    - any valid bit in stages 0..curLat-1
//   latErrOut  - one-cycle pulse per clamped latency load
module delay_pipe #(
   parameter int unsigned MAX_LATENCY = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned LAT_WIDTH   = 5
) (
   input  logic                         clkIn,
   input  logic                         rstIn,
   input  logic                         enIn,
   input  logic                         flushIn,
   input  logic [LAT_WIDTH-1:0]         latencyIn,
   input  logic                         validIn,
   input  logic [NUM_CH*DATA_WIDTH-1:0] dataIn,
   output logic                         validOut,
   output logic [NUM_CH*DATA_WIDTH-1:0] dataOut,
   output logic                         busyOut,
   output logic                         latErrOut
);

   localparam int unsigned DW = NUM_CH * DATA_WIDTH;
   localparam logic [LAT_WIDTH-1:0] MaxLat = LAT_WIDTH'(MAX_LATENCY);

   logic [MAX_LATENCY-1:0] valid_q, valid_d;
   logic [DW-1:0]          data_q [MAX_LATENCY];
   logic [DW-1:0]          data_d [MAX_LATENCY];
   logic [LAT_WIDTH-1:0]   cur_lat_q, cur_lat_d;
   logic                   lat_err_q, lat_err_d;

   logic                   busy;
   logic                   load;
   logic                   req_bad;
   logic [LAT_WIDTH-1:0]   req_lat;

   // Only stages inside the active depth count; stale tags beyond it are ignored.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < int'(MAX_LATENCY); i++) begin
         if (valid_q[i] && (LAT_WIDTH'(i) < cur_lat_q)) busy = 1'b1;
      end
   end

   always_comb begin
      req_bad = 1'b0;
      req_lat = latencyIn;
      if (latencyIn == '0) begin
         req_bad = 1'b1;
         req_lat = LAT_WIDTH'(1);
      end else if (latencyIn > MaxLat) begin
         req_bad = 1'b1;
         req_lat = MaxLat;
      end
   end

   // A clamped request never matches curLat, so it reloads (and re-flags) every idle cycle.
   assign load = !flushIn && !busy && (latencyIn != cur_lat_q);

   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      cur_lat_d = cur_lat_q;
      lat_err_d = 1'b0;
      if (flushIn) begin
         valid_d = '0;
      end else begin
         if (enIn) begin
            valid_d[0] = validIn;
            data_d[0]  = dataIn;
            for (int i = 1; i < int'(MAX_LATENCY); i++) begin
               valid_d[i] = valid_q[i-1];
               data_d[i]  = data_q[i-1];
            end
         end
         if (load) begin
            // Stage 0 keeps its fresh sample so it runs at the new latency.
            for (int i = 1; i < int'(MAX_LATENCY); i++) valid_d[i] = 1'b0;
            cur_lat_d = req_lat;
            lat_err_d = req_bad;
         end
      end
   end

   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         valid_q   <= '0;
         cur_lat_q <= MaxLat;
         lat_err_q <= 1'b0;
         for (int i = 0; i < int'(MAX_LATENCY); i++) data_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         cur_lat_q <= cur_lat_d;
         lat_err_q <= lat_err_d;
         for (int i = 0; i < int'(MAX_LATENCY); i++) data_q[i] <= data_d[i];
      end
   end

   // Output tap: stage curLat-1, straight from the registers.
   always_comb begin
      validOut = 1'b0;
      dataOut  = '0;
      for (int i = 0; i < int'(MAX_LATENCY); i++) begin
         if (LAT_WIDTH'(i + 1) == cur_lat_q) begin
            validOut = valid_q[i];
            dataOut  = data_q[i];
         end
      end
   end

   assign busyOut   = busy;
   assign latErrOut = lat_err_q;

endmodule

// File: tb/tb_delay_pipe.sv
// tb_delay_pipe: directed and random stimulus for delay_pipe, checked every cycle against
// a queue-based model of the stage chain plus hand-computed literal expectations.
module tb_delay_pipe;

   localparam int unsigned MAX = 16;
   localparam int unsigned DWC = 32;
   localparam int unsigned NCH = 4;
   localparam int unsigned LW  = 5;
   localparam int unsigned DW  = NCH * DWC;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          flush;
   logic [LW-1:0] lat;
   logic          vin;
   logic [DW-1:0] din;
   logic          vout;
   logic [DW-1:0] dout;
   logic          busy;
   logic          lat_err;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 0;

   delay_pipe #(
      .MAX_LATENCY(MAX),
      .DATA_WIDTH (DWC),
      .NUM_CH     (NCH),
      .LAT_WIDTH  (LW)
   ) dut (
      .clkIn    (clk),
      .rstIn    (rst_n),
      .enIn     (en),
      .flushIn  (flush),
      .latencyIn(lat),
      .validIn  (vin),
      .dataIn   (din),
      .validOut (vout),
      .dataOut  (dout),
      .busyOut  (busy),
      .latErrOut(lat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   typedef struct packed {
      logic          v;
      logic [DW-1:0] d;
   } stage_t;

   stage_t m_q[$];
   int     m_lat;
   bit     m_err;

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < int'(MAX); i++) m_q.push_back('0);
      m_lat = MAX;
      m_err = 1'b0;
   endtask

   task automatic model_step();
      bit     m_busy;
      bit     do_load;
      bit     bad;
      int     req;
      int     clamped;
      stage_t s;
      m_busy = 1'b0;
      for (int i = 0; i < m_lat; i++) if (m_q[i].v) m_busy = 1'b1;
      req     = int'(lat);
      bad     = (req == 0) || (req > int'(MAX));
      clamped = (req == 0) ? 1 : ((req > int'(MAX)) ? int'(MAX) : req);
      do_load = !flush && !m_busy && (req != m_lat);
      if (flush) begin
         for (int i = 0; i < int'(MAX); i++) m_q[i].v = 1'b0;
      end else begin
         if (en) begin
            s.v = vin;
            s.d = din;
            m_q.push_front(s);
            void'(m_q.pop_back());
         end
         if (do_load) for (int i = 1; i < int'(MAX); i++) m_q[i].v = 1'b0;
      end
      if (do_load) begin
         m_lat = clamped;
         m_err = bad;
      end else begin
         m_err = 1'b0;
      end
   endtask

   initial model_reset();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         bit m_busy;
         m_busy = 1'b0;
         for (int i = 0; i < m_lat; i++) if (m_q[i].v) m_busy = 1'b1;
         check("model validOut", DW'(vout), DW'(m_q[m_lat-1].v));
         check("model dataOut", dout, m_q[m_lat-1].d);
         check("model busyOut", DW'(busy), DW'(m_busy));
         check("model latErrOut", DW'(lat_err), DW'(m_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      en    = 1'b1;
      flush = 1'b0;
      vin   = 1'b0;
      repeat (MAX + 2) tick();
   endtask

   function automatic logic [DW-1:0] pat(input logic [7:0] tag);
      return {4'h3, 20'h0, tag, 4'h2, 20'h0, tag, 4'h1, 20'h0, tag, 4'h0, 20'h0, tag};
   endfunction

   // Program latency L, push one sample, check the output pulses exactly after edge L-1.
   task automatic lat_pulse(input int l, input logic [7:0] tag);
      drain();
      lat = LW'(l);
      tick();
      tick();
      vin = 1'b1;
      din = pat(tag);
      for (int e = 0; e <= l + 1; e++) begin
         tick();
         vin = 1'b0;
         if (e == 0) check("pulse busy after push", DW'(busy), DW'(1));
         check($sformatf("pulse L=%0d valid e=%0d", l, e), DW'(vout), DW'(e == l - 1));
         if (e == l - 1) check($sformatf("pulse L=%0d data", l), dout, pat(tag));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      flush = 1'b0;
      lat   = LW'(MAX);
      vin   = 1'b0;
      din   = '0;
      repeat (3) @(negedge clk);
      check("reset validOut", DW'(vout), '0);
      check("reset dataOut", dout, '0);
      check("reset busyOut", DW'(busy), '0);
      check("reset latErrOut", DW'(lat_err), '0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // 1: asynchronous reset in the middle of a stream
      en  = 1'b1;
      lat = LW'(5);
      tick();
      tick();
      vin = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = pat(8'(i + 1));
         tick();
      end
      check("stream busy before reset", DW'(busy), DW'(1));
      #2 rst_n = 1'b0;
      #1;
      check("async reset validOut", DW'(vout), '0);
      check("async reset dataOut", dout, '0);
      check("async reset busyOut", DW'(busy), '0);
      @(negedge clk);
      rst_n = 1'b1;
      vin   = 1'b0;
      repeat (20) tick();
      check("idle after reset validOut", DW'(vout), '0);
      check("idle after reset busyOut", DW'(busy), '0);

      // 2: single-sample latency at 3, 1 and max
      lat_pulse(3, 8'hA5);
      lat_pulse(1, 8'hA5);
      lat_pulse(16, 8'hA5);

      // 3: stall at L=4, enable low for edges 2..4 -> output after edge 6
      drain();
      lat = LW'(4);
      tick();
      tick();
      for (int e = 0; e <= 8; e++) begin
         en  = !(e >= 2 && e <= 4);
         vin = (e == 0);
         din = pat(8'h5C);
         tick();
         check($sformatf("stall valid e=%0d", e), DW'(vout), DW'(e == 6));
         if (e == 6) check("stall data", dout, pat(8'h5C));
      end
      en = 1'b1;
      // back-to-back samples keep order and per-channel data
      drain();
      for (int e = 0; e <= 6; e++) begin
         vin = (e <= 2);
         din = pat(8'(8'h10 + e));
         tick();
         check($sformatf("b2b valid e=%0d", e), DW'(vout), DW'(e >= 3 && e <= 5));
         if (e >= 3 && e <= 5) check($sformatf("b2b data e=%0d", e), dout, pat(8'(8'h10 + e - 3)));
      end

      // 4: flush with three samples in flight and a sample on the input
      drain();
      lat = LW'(6);
      tick();
      tick();
      for (int e = 0; e < 3; e++) begin
         vin = 1'b1;
         din = pat(8'(8'h20 + e));
         tick();
      end
      flush = 1'b1;
      vin   = 1'b1;
      din   = pat(8'h2F);
      tick();
      flush = 1'b0;
      vin   = 1'b0;
      check("flush busy", DW'(busy), '0);
      for (int e = 0; e < 10; e++) begin
         tick();
         check($sformatf("flush no valid e=%0d", e), DW'(vout), '0);
      end

      // 5: latency change held off while busy, then applied
      drain();
      lat = LW'(4);
      tick();
      tick();
      for (int e = 0; e <= 16; e++) begin
         vin = (e <= 1) || (e == 7);
         din = pat(8'(8'h40 + e));
         if (e >= 2) lat = LW'(8);
         tick();
         check($sformatf("latchg valid e=%0d", e), DW'(vout), DW'(e == 3 || e == 4 || e == 14));
         if (e == 5) check("latchg drained busy", DW'(busy), '0);
         if (e == 14) check("latchg data", dout, pat(8'h47));
      end
      drain();
      lat = '0;
      tick();
      check("lat 0 err pulse", DW'(lat_err), DW'(1));
      tick();
      check("lat 0 err persists", DW'(lat_err), DW'(1));
      lat = LW'(1);
      tick();
      check("lat 1 err clear", DW'(lat_err), '0);
      vin = 1'b1;
      din = pat(8'h77);
      tick();
      vin = 1'b0;
      check("clamped L=1 valid", DW'(vout), DW'(1));
      check("clamped L=1 data", dout, pat(8'h77));
      tick();
      lat = LW'(20);
      tick();
      check("lat 20 err pulse", DW'(lat_err), DW'(1));
      lat = LW'(16);
      tick();
      check("lat 16 no load err", DW'(lat_err), '0);

      // 6: random traffic, model comparison only
      for (int c = 0; c < 10000; c++) begin
         en    = ($urandom_range(3) != 0);
         vin   = $urandom_range(1) == 1;
         flush = ($urandom_range(39) == 0);
         din   = {$urandom(), $urandom(), $urandom(), $urandom()};
         if ($urandom_range(49) == 0) lat = LW'($urandom_range(20));
         tick();
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
